uart_reg_tx_module: RTL
=======================

Name: uart_reg_tx_module

Overview:
Word-level UART transmitter.
- Accepts REG_WIDTH-bit words over a valid/ready handshake and buffers them in an internal FIFO.
- Splits each word into bytes and sends each byte as an 8N1 frame on uart_tx_port.
- After every word, holds the line idle for IDLE_CYCLE bit times, so the word-level UART receiver sees a frame boundary and regroups the bytes into one word.

Parameters:
CLK_FRE, 50, system clock in MHz (integer)
BPS, 115200, baud rate; BIT_CYC = (CLK_FRE*1000000)/BPS, integer truncation, must be >= 2
IDLE_CYCLE, 20, idle bit-times inserted after the last byte of each word (>= 1)
REG_WIDTH, 32, word width; multiple of 8, NBYTE = REG_WIDTH/8 >= 1
FIFO_DEPTH, 8, word FIFO depth; power of 2, >= 2
MSB_FIRST, 1, 1: byte [REG_WIDTH-1:REG_WIDTH-8] sent first; 0: byte [7:0] sent first

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
uart_tx_data  input  REG_WIDTH  word to send
uart_tx_valid  input  1  uart_tx_data valid
uart_tx_ready  output  1  FIFO not full; word accepted when valid && ready at clk rise
uart_tx_port  output  1  serial line, idle high
uart_tx_busy  output  1  high while FIFO non-empty or any state other than IDLE

Behaviour:
- Reset (asynchronous, rst_n low):
  - uart_tx_port=1, uart_tx_ready=1, uart_tx_busy=0.
  - FIFO emptied, FSM forced to IDLE, all counters cleared.
  - Reset in mid-frame drops the partial word; the line goes high immediately, not at the next clock edge.
- FIFO:
  - Synchronous FIFO with registered pointers; uart_tx_ready = !full.
  - Pushes while full cannot happen (ready low); valid without ready is ignored and the word is not lost upstream.
  - Push and pop in the same cycle are both performed; count is unchanged.
- FSM states: IDLE, LOAD, START, DATA, STOP, GAP.
  - IDLE: port=1. If FIFO non-empty -> LOAD.
  - LOAD (1 cycle): pop the FIFO head into the word shift register, byte_idx=0 -> START.
  - START: port=0 for BIT_CYC cycles -> DATA.
  - DATA: 8 bits, LSB first, each held BIT_CYC cycles -> STOP.
  - STOP: port=1 for BIT_CYC cycles.
    - If byte_idx < NBYTE-1: byte_idx++, shift the word register by 8 -> START. No gap between bytes of one word.
    - Else -> GAP.
  - GAP: port=1 for IDLE_CYCLE*BIT_CYC cycles -> IDLE.
- Timing:
  - A word pushed into an empty FIFO while in IDLE drives the start bit 2 cycles after the accept edge (IDLE->LOAD->START).
  - A word occupies NBYTE*10*BIT_CYC + IDLE_CYCLE*BIT_CYC cycles of line time, plus 2 cycles of IDLE/LOAD overhead between consecutive words.
- Bit timer: counts 0..BIT_CYC-1 and wraps; it is reloaded to 0 on every state change.
- Byte selection: MSB_FIRST=1 shifts left and sends the upper byte; MSB_FIRST=0 shifts right and sends the lower byte.
- uart_tx_port is driven from a flop (glitch-free).
- uart_tx_busy is combinational from FIFO empty and FSM state.

Decomposition:
- Shared package uart_pkg holds:
  - tx state enum (IDLE..GAP);
  - constant function bit_cyc(CLK_FRE,BPS);
  - 8N1 framing constants: START_BIT=0, STOP_BIT=1, DATA_BITS=8.
- One sub-module, uart_bit_tx_module, contains the byte framing, bit timer and port flop:
  - inputs: byte_data[7:0], byte_valid;
  - outputs: byte_ready, tx_pin.
- The top level keeps the FIFO, byte sequencer and GAP timer.

Test Plan:
All scenarios use CLK_FRE=1, BPS=100000 (BIT_CYC=10), IDLE_CYCLE=2, REG_WIDTH=32, FIFO_DEPTH=4.
1. Reset: hold rst_n=0 with valid=1 -> port=1, ready=1, busy=0. Release rst_n -> no transmission starts until a word is accepted.
2. Single word 0x12345678, MSB_FIRST=1 -> line-decoded bytes are 0x12,0x34,0x56,0x78.
   - First start bit falls 2 cycles after the accept edge.
   - Each frame is 100 cycles; the four frames are back-to-back.
   - Line stays high for 20 cycles after the last stop bit, then busy=0.
3. MSB_FIRST=0, word 0xA5C3F00F -> bytes 0x0F,0xF0,0xC3,0xA5; data bit order checked LSB first within each byte.
4. Burst of 5 consecutive words with valid held high:
   - Ready drops after 5 accepts: 4 in the FIFO plus 1 taken by LOAD, so full occurs after the 5th push.
   - Ready re-asserts one cycle after the next LOAD pop.
   - All 5 words are received in order, separated by the 20-cycle gap plus 2 overhead cycles.
5. Reset asserted mid-DATA of byte 2 -> port high asynchronously, FIFO flushed. After release, a new word 0xDEADBEEF is sent intact.
6. Push into a full FIFO in the same cycle as a LOAD pop -> word accepted only if ready=1 that cycle; no duplicated or dropped words (scoreboard check).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the word-level UART transmitter.
// Holds the tx state encoding, 8N1 framing constants and the bit-period helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4,
    GAP   = 3'd5
  } tx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  // Clock cycles per bit, truncated.
  function automatic int bit_cyc(input int clk_fre, input int bps);
    return (clk_fre * 1000000) / bps;
  endfunction

endpackage

// File: rtl/uart_bit_tx_module.sv
// 8N1 byte framer: start bit, 8 data bits LSB first, stop bit, each BIT_CYC cycles.
// A byte offered during the last stop-bit cycle starts immediately, so bytes run back-to-back.
module uart_bit_tx_module
  import uart_pkg::*;
#(
  parameter int BIT_CYC = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       tx_pin,
  output tx_state_t  state
);

  localparam int TW = $clog2(BIT_CYC);

  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_end;

  assign bit_end    = (timer == TW'(BIT_CYC - 1));
  assign byte_ready = (state == IDLE) || ((state == STOP) && bit_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_pin  <= STOP_BIT;
    end else begin
      case (state)
        IDLE: begin
          timer  <= '0;
          tx_pin <= STOP_BIT;
          if (byte_valid) begin
            state  <= START;
            shreg  <= byte_data;
            tx_pin <= START_BIT;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            timer   <= '0;
            bit_idx <= '0;
            tx_pin  <= shreg[0];
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            timer <= '0;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              state  <= STOP;
              tx_pin <= STOP_BIT;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg >> 1;
              tx_pin  <= shreg[1];
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            timer <= '0;
            if (byte_valid) begin
              state  <= START;
              shreg  <= byte_data;
              tx_pin <= START_BIT;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          tx_pin <= STOP_BIT;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_reg_tx_module.sv
// Word-level UART transmitter: word FIFO, byte sequencer and inter-word idle gap.
// Each word is sent as NBYTE back-to-back 8N1 frames followed by IDLE_CYCLE idle bit times.
module uart_reg_tx_module
  import uart_pkg::*;
#(
  parameter int CLK_FRE    = 50,
  parameter int BPS        = 115200,
  parameter int IDLE_CYCLE = 20,
  parameter int REG_WIDTH  = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int MSB_FIRST  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_WIDTH-1:0] uart_tx_data,
  input  logic                 uart_tx_valid,
  output logic                 uart_tx_ready,
  output logic                 uart_tx_port,
  output logic                 uart_tx_busy
);

  localparam int BIT_CYC = bit_cyc(CLK_FRE, BPS);
  localparam int NBYTE   = REG_WIDTH / 8;
  localparam int GAP_CYC = IDLE_CYCLE * BIT_CYC;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int GW      = $clog2(GAP_CYC);
  localparam int IW      = (NBYTE > 1) ? $clog2(NBYTE) : 1;

  function automatic logic [7:0] first_byte(input logic [REG_WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[REG_WIDTH-1 -: 8] : w[7:0];
  endfunction

  function automatic logic [REG_WIDTH-1:0] next_word(input logic [REG_WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 8) : (w >> 8);
  endfunction

  // Handshake: a word transfers on a rising clk edge where uart_tx_valid && uart_tx_ready;
  // ready depends only on FIFO fullness, never on valid.
  logic [REG_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 full, empty, push, pop;
  logic [REG_WIDTH-1:0] head;

  tx_state_t            seq_state, bit_state;
  logic [REG_WIDTH-1:0] word_reg;
  logic [IW-1:0]        byte_idx;
  logic [GW-1:0]        gap_cnt;
  logic                 byte_valid, byte_ready;
  logic [7:0]           byte_data;

  assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty         = (wr_ptr == rd_ptr);
  assign push          = uart_tx_valid && !full;
  assign pop           = (seq_state == LOAD);
  assign head          = mem[rd_ptr[AW-1:0]];
  assign uart_tx_ready = !full;
  assign uart_tx_busy  = !empty || (seq_state != IDLE) || (bit_state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= uart_tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // The first byte is offered straight from the FIFO head during LOAD so the
  // start bit begins on the edge that leaves LOAD.
  assign byte_valid = (seq_state == LOAD) ||
                      ((seq_state == DATA) && (byte_idx != IW'(NBYTE - 1)));
  assign byte_data  = (seq_state == LOAD) ? first_byte(head) : first_byte(word_reg);

  // DATA here means "bytes of the current word are on the line"; the framer
  // reports its own START/DATA/STOP phase through bit_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_state <= IDLE;
      word_reg  <= '0;
      byte_idx  <= '0;
      gap_cnt   <= '0;
    end else begin
      case (seq_state)
        IDLE: begin
          gap_cnt <= '0;
          if (!empty) seq_state <= LOAD;
        end
        LOAD: begin
          word_reg  <= next_word(head);
          byte_idx  <= '0;
          seq_state <= DATA;
        end
        DATA: begin
          if (byte_ready) begin
            if (byte_idx == IW'(NBYTE - 1)) begin
              seq_state <= GAP;
              gap_cnt   <= '0;
            end else begin
              byte_idx <= byte_idx + 1'b1;
              word_reg <= next_word(word_reg);
            end
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYC - 1)) begin
            seq_state <= IDLE;
            gap_cnt   <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: seq_state <= IDLE;
      endcase
    end
  end

  uart_bit_tx_module #(
    .BIT_CYC(BIT_CYC)
  ) u_bit_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .tx_pin    (uart_tx_port),
    .state     (bit_state)
  );

endmodule
